ntt_pair_scheduler: RTL and testbench

Sequencing controller for the in-place radix-2 NTT/INTT datapath: walks every stage of a 2^log_n-point transform, issuing one coefficient-pair read (two addresses) plus a twiddle ROM index per cycle to the butterfly, and issuing the matching write-back addresses after the fixed datapath latency. It sits between the coefficient RAM / twiddle ROM and the radix-2 butterfly core, on the producer and consumer side of the butterfly's operand and result pairs. Twiddle_1 of the butterfly is tied to one outside this block. INTT n^-1 scaling is out of scope.

---
 rtl/ntt_pair_scheduler_pkg.sv | 19 +
 rtl/ntt_pair_scheduler_wb_delay.sv | 44 ++++
 rtl/ntt_pair_scheduler.sv | 158 +++++++++++++++
 tb/tb_ntt_pair_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pair_scheduler_pkg.sv
// Shared definitions for the radix-2 NTT/INTT pair scheduler:
// default sizing, FSM state type and butterfly mode constants.
package ntt_pair_scheduler_pkg;

    localparam int unsigned LOG_N_DEF    = 8;
    localparam int unsigned PIPE_LAT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Must match the butterfly select encoding.
    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

endpackage

// File: rtl/ntt_pair_scheduler_wb_delay.sv
// Write-back delay line: {valid, addr_1, addr_2} shifted PIPE_LAT cycles,
// cleared synchronously so no write survives a reset.
module ntt_wb_delay
    import ntt_pair_scheduler_pkg::*;
#(
    parameter int unsigned LOG_N    = LOG_N_DEF,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [LOG_N-1:0] addr_1_i,
    input  logic [LOG_N-1:0] addr_2_i,
    output logic             valid_o,
    output logic [LOG_N-1:0] addr_1_o,
    output logic [LOG_N-1:0] addr_2_o
);

    typedef struct packed {
        logic             valid;
        logic [LOG_N-1:0] a1;
        logic [LOG_N-1:0] a2;
    } slot_t;

    slot_t line_q [PIPE_LAT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q[0] <= {valid_i, addr_1_i, addr_2_i};
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    assign valid_o  = line_q[PIPE_LAT-1].valid;
    assign addr_1_o = line_q[PIPE_LAT-1].a1;
    assign addr_2_o = line_q[PIPE_LAT-1].a2;

endmodule

// File: rtl/ntt_pair_scheduler.sv
// Stage/pair sequencer for the in-place radix-2 NTT (CT) / INTT (GS) datapath:
// issues one butterfly pair read plus twiddle index per cycle, then write-back.
module ntt_pair_scheduler
    import ntt_pair_scheduler_pkg::*;
#(
    parameter int unsigned LOG_N    = LOG_N_DEF,
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             select_i,
    output logic             mode_o,
    output logic             rd_en_o,
    output logic [LOG_N-1:0] rd_addr_1_o,
    output logic [LOG_N-1:0] rd_addr_2_o,
    output logic [LOG_N-1:0] tw_addr_o,
    output logic             wr_en_o,
    output logic [LOG_N-1:0] wr_addr_1_o,
    output logic [LOG_N-1:0] wr_addr_2_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned LTW = $clog2(LOG_N + 1);
    localparam int unsigned KW  = LOG_N - 1;
    localparam int unsigned DW  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [LTW-1:0]   LT_MAX = LTW'(LOG_N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(PIPE_LAT - 1);
    localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);

    state_e           state_q, state_d;
    logic [LTW-1:0]   s_q, s_d;
    logic [KW-1:0]    k_q, k_d;
    logic [DW-1:0]    d_q, d_d;
    logic             mode_q, mode_d;

    logic             rd_en_q, rd_en_d;
    logic [LOG_N-1:0] rd_a1_q, rd_a1_d;
    logic [LOG_N-1:0] rd_a2_q, rd_a2_d;
    logic [LOG_N-1:0] tw_q, tw_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [LTW-1:0]   lt;
    logic [LOG_N-1:0] k_ext, i_w, j_w, a1_w;

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            d_q     <= '0;
            mode_q  <= MODE_NTT;
            rd_en_q <= 1'b0;
            rd_a1_q <= '0;
            rd_a2_q <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            d_q     <= d_d;
            mode_q  <= mode_d;
            rd_en_q <= rd_en_d;
            rd_a1_q <= rd_a1_d;
            rd_a2_q <= rd_a2_d;
            tw_q    <= tw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        d_d     = d_q;
        mode_d  = mode_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ISSUE;
                    mode_d  = select_i;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            ST_ISSUE: begin
                if (k_q == '1) begin
                    state_d = ST_DRAIN;
                    d_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            // Hold off the next stage until its last write-back has landed.
            ST_DRAIN: begin
                if (d_q == D_LAST) begin
                    if (s_q == LT_MAX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        s_d     = s_q + 1'b1;
                        k_d     = '0;
                    end
                end else begin
                    d_d = d_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lt    = (mode_d == MODE_INTT) ? s_d : (LT_MAX - s_d);
        k_ext = {1'b0, k_d};
        i_w   = k_ext >> lt;
        j_w   = k_ext & ((ONE << lt) - ONE);
        a1_w  = (i_w << (lt + LTW'(1))) | j_w;

        rd_en_d = (state_d == ST_ISSUE);
        rd_a1_d = rd_en_d ? a1_w : '0;
        rd_a2_d = rd_en_d ? (a1_w | (ONE << lt)) : '0;
        // n >> (lt+1) written as a shift of one to stay within log_n bits.
        tw_d    = rd_en_d ? ((ONE << (LT_MAX - lt)) + i_w) : '0;
        busy_d  = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
    end

    ntt_wb_delay #(
        .LOG_N    (LOG_N),
        .PIPE_LAT (PIPE_LAT)
    ) u_wb_delay (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (rd_en_q),
        .addr_1_i (rd_a1_q),
        .addr_2_i (rd_a2_q),
        .valid_o  (wr_en_o),
        .addr_1_o (wr_addr_1_o),
        .addr_2_o (wr_addr_2_o)
    );

    assign mode_o      = mode_q;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_1_o = rd_a1_q;
    assign rd_addr_2_o = rd_a2_q;
    assign tw_addr_o   = tw_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_ntt_pair_scheduler.sv
// Bench for ntt_pair_scheduler: a small (log_n=3, lat=2) and a large (log_n=8, lat=4)
// instance checked cycle by cycle against a loop-nest model of the butterfly schedule.
module tb_ntt_pair_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s = 1'b0, sel_s = 1'b0;
    logic start_l = 1'b0, sel_l = 1'b0;

    logic       mode_s, rd_en_s, wr_en_s, busy_s, done_s;
    logic [2:0] rd1_s, rd2_s, tw_s, wr1_s, wr2_s;
    logic       mode_l, rd_en_l, wr_en_l, busy_l, done_l;
    logic [7:0] rd1_l, rd2_l, tw_l, wr1_l, wr2_l;

    int vectors = 0;
    int miscompares = 0;

    bit exp_en    [0:1199];
    int exp_a1    [0:1199];
    int exp_a2    [0:1199];
    int exp_tw    [0:1199];
    int exp_stage [0:1199];
    int exp_T;
    bit obs_en    [0:1199];
    int obs_a1    [0:1199];
    int obs_a2    [0:1199];

    always #5 clk = ~clk;

    ntt_pair_scheduler #(.LOG_N(3), .PIPE_LAT(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start_s), .select_i(sel_s),
        .mode_o(mode_s), .rd_en_o(rd_en_s), .rd_addr_1_o(rd1_s), .rd_addr_2_o(rd2_s),
        .tw_addr_o(tw_s), .wr_en_o(wr_en_s), .wr_addr_1_o(wr1_s), .wr_addr_2_o(wr2_s),
        .busy_o(busy_s), .done_o(done_s)
    );

    ntt_pair_scheduler #(.LOG_N(8), .PIPE_LAT(4)) dut_l (
        .clk_i(clk), .rst_i(rst), .start_i(start_l), .select_i(sel_l),
        .mode_o(mode_l), .rd_en_o(rd_en_l), .rd_addr_1_o(rd1_l), .rd_addr_2_o(rd2_l),
        .tw_addr_o(tw_l), .wr_en_o(wr_en_l), .wr_addr_1_o(wr1_l), .wr_addr_2_o(wr2_l),
        .busy_o(busy_l), .done_o(done_l)
    );

    // Textbook in-place loop nest: per stage a butterfly span 'len', blocks of 2*len,
    // twiddle index counting up per block from n/(2*len) (bit-reversed ROM order).
    task automatic build_model(input int ln, input int lat, input bit sel);
        int n, c, len, blocks;
        n = 1 << ln;
        for (int x = 0; x < 1200; x++) begin
            exp_en[x] = 1'b0; exp_a1[x] = 0; exp_a2[x] = 0; exp_tw[x] = 0; exp_stage[x] = -1;
        end
        c = 1;
        for (int st = 0; st < ln; st++) begin
            len    = sel ? (1 << st) : (n >> (st + 1));
            blocks = n / (2 * len);
            for (int b = 0; b < blocks; b++) begin
                for (int j = 0; j < len; j++) begin
                    exp_en[c]    = 1'b1;
                    exp_a1[c]    = b * 2 * len + j;
                    exp_a2[c]    = exp_a1[c] + len;
                    exp_tw[c]    = blocks + b;
                    exp_stage[c] = st;
                    c++;
                end
            end
            c += lat;
        end
        exp_T = c;
    endtask

    task automatic drive(input bit big, input logic st, input logic sl);
        if (big) begin start_l = st; sel_l = sl; end
        else     begin start_s = st; sel_s = sl; end
    endtask

    task automatic run_xfer(input string name, input bit big, input bit sel, input bit disturb);
        int ln, lat, T, done_cycle, wr_count, exp_reads, cur_stage, ew1, ew2;
        bit en, wen, bsy, dn, md, exp_wen;
        int a1, a2, tw, w1, w2;
        bit seen [256];
        ln  = big ? 8 : 3;
        lat = big ? 4 : 2;
        build_model(ln, lat, sel);
        T = exp_T;
        exp_reads = 0;
        for (int x = 0; x < 1200; x++) if (exp_en[x]) exp_reads++;
        drive(big, 1'b1, sel);
        @(negedge clk);
        drive(big, 1'b0, disturb ? 1'($urandom_range(0, 1)) : sel);
        done_cycle = -1; wr_count = 0; cur_stage = -1;
        for (int x = 0; x < 256; x++) seen[x] = 1'b0;
        for (int c = 1; c <= T + 1; c++) begin
            if (big) begin
                en = rd_en_l; a1 = int'(rd1_l); a2 = int'(rd2_l); tw = int'(tw_l);
                wen = wr_en_l; w1 = int'(wr1_l); w2 = int'(wr2_l);
                bsy = busy_l; dn = done_l; md = mode_l;
            end else begin
                en = rd_en_s; a1 = int'(rd1_s); a2 = int'(rd2_s); tw = int'(tw_s);
                wen = wr_en_s; w1 = int'(wr1_s); w2 = int'(wr2_s);
                bsy = busy_s; dn = done_s; md = mode_s;
            end
            obs_en[c] = en; obs_a1[c] = a1; obs_a2[c] = a2;
            exp_wen = (c - lat >= 1) ? exp_en[c - lat] : 1'b0;
            ew1 = (c - lat >= 1) ? exp_a1[c - lat] : 0;
            ew2 = (c - lat >= 1) ? exp_a2[c - lat] : 0;

            vectors++;
            if (en !== exp_en[c]) begin
                miscompares++;
                $display("FAIL %s rd_en cycle %0d: got %0b want %0b", name, c, en, exp_en[c]);
            end
            if (exp_en[c] && en) begin
                vectors++;
                if (a1 !== exp_a1[c] || a2 !== exp_a2[c] || tw !== exp_tw[c]) begin
                    miscompares++;
                    $display("FAIL %s rd_pair cycle %0d: got (%0d,%0d) tw %0d want (%0d,%0d) tw %0d",
                             name, c, a1, a2, tw, exp_a1[c], exp_a2[c], exp_tw[c]);
                end
                if (exp_stage[c] != cur_stage) begin
                    cur_stage = exp_stage[c];
                    for (int x = 0; x < 256; x++) seen[x] = 1'b0;
                end
                vectors++;
                if (seen[a1[7:0]] || seen[a2[7:0]]) begin
                    miscompares++;
                    $display("FAIL %s addr_repeat cycle %0d: got (%0d,%0d) want unseen in stage %0d",
                             name, c, a1, a2, cur_stage);
                end
                seen[a1[7:0]] = 1'b1; seen[a2[7:0]] = 1'b1;
            end
            vectors++;
            if (wen !== exp_wen) begin
                miscompares++;
                $display("FAIL %s wr_en cycle %0d: got %0b want %0b", name, c, wen, exp_wen);
            end
            if (wen && exp_wen) begin
                vectors++;
                if (w1 !== ew1 || w2 !== ew2) begin
                    miscompares++;
                    $display("FAIL %s wr_pair cycle %0d: got (%0d,%0d) want (%0d,%0d)",
                             name, c, w1, w2, ew1, ew2);
                end
            end
            if (c > lat) begin
                vectors++;
                if (wen !== obs_en[c - lat] || (wen && (w1 !== obs_a1[c - lat] || w2 !== obs_a2[c - lat]))) begin
                    miscompares++;
                    $display("FAIL %s wr_vs_rd cycle %0d: got %0b (%0d,%0d) want %0b (%0d,%0d)",
                             name, c, wen, w1, w2, obs_en[c - lat], obs_a1[c - lat], obs_a2[c - lat]);
                end
            end
            vectors++;
            if (bsy !== (c < T) || dn !== (c == T)) begin
                miscompares++;
                $display("FAIL %s busy_done cycle %0d: got busy %0b done %0b want busy %0b done %0b",
                         name, c, bsy, dn, (c < T), (c == T));
            end
            if (c <= T) begin
                vectors++;
                if (md !== sel) begin
                    miscompares++;
                    $display("FAIL %s mode cycle %0d: got %0b want %0b", name, c, md, sel);
                end
            end
            if (dn && done_cycle < 0) done_cycle = c;
            if (wen) wr_count++;
            if (disturb && c <= T) drive(big, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else drive(big, 1'b0, big ? sel_l : sel_s);
            if (c <= T) @(negedge clk);
        end
        vectors++;
        if (done_cycle !== (big ? 1057 : 19)) begin
            miscompares++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_cycle, big ? 1057 : 19);
        end
        vectors++;
        if (wr_count !== exp_reads) begin
            miscompares++;
            $display("FAIL %s wr_count: got %0d want %0d", name, wr_count, exp_reads);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            vectors++;
            if ({mode_s, rd_en_s, wr_en_s, busy_s, done_s, rd1_s, rd2_s, tw_s, wr1_s, wr2_s} !== 20'h0) begin
                miscompares++;
                $display("FAIL reset_small: got %b want all zero",
                         {mode_s, rd_en_s, wr_en_s, busy_s, done_s, rd1_s, rd2_s, tw_s, wr1_s, wr2_s});
            end
            vectors++;
            if ({mode_l, rd_en_l, wr_en_l, busy_l, done_l, rd1_l, rd2_l, tw_l, wr1_l, wr2_l} !== 45'h0) begin
                miscompares++;
                $display("FAIL reset_large: got %b want all zero",
                         {mode_l, rd_en_l, wr_en_l, busy_l, done_l, rd1_l, rd2_l, tw_l, wr1_l, wr2_l});
            end
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int kk, c_r, n_seen;
        build_model(3, 2, 1'b0);
        kk = $urandom_range(0, 3);
        c_r = 1; n_seen = 0;
        for (int c = 1; c < exp_T; c++) begin
            if (exp_en[c] && exp_stage[c] == 1) begin
                if (n_seen == kk) c_r = c;
                n_seen++;
            end
        end
        drive(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= c_r; c++) begin
            if (c == c_r) begin
                vectors++;
                if (rd_en_s !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rst_mid pre_read cycle %0d: got %0b want 1", c, rd_en_s);
                end
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy_s !== 1'b0 || rd_en_s !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid after_rst: got busy %0b rd_en %0b want 0 0", busy_s, rd_en_s);
        end
        for (int c = 0; c < 7; c++) begin
            vectors++;
            if (wr_en_s !== 1'b0 || busy_s !== 1'b0 || done_s !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid quiet %0d: got wr %0b busy %0b done %0b want 0 0 0",
                         c, wr_en_s, busy_s, done_s);
            end
            @(negedge clk);
        end
        run_xfer("ntt_after_rst", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        test_reset();
        run_xfer("ntt_small", 1'b0, 1'b0, 1'b0);
        gap();
        run_xfer("intt_small", 1'b0, 1'b1, 1'b0);
        gap();
        run_xfer("disturb_small", 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        run_xfer("back_to_back", 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        gap();
        test_reset_midrun();
        gap();
        run_xfer("ntt_large", 1'b1, 1'b0, 1'b0);
        run_xfer("large_random", 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
